// File: rtl/pwm_pkg.sv
// pwm_pkg: shared register map and ramp FSM state encoding for the compare-ramp stage.
// Contents: REG_* register addresses, ramp_state_t.
package pwm_pkg;
    localparam int REG_CMP0    = 0;
    localparam int REG_CMP1    = 1;
    localparam int REG_CMP2    = 2;
    localparam int REG_COMMIT  = 3;
    localparam int REG_STEP_LO = 4;
    localparam int REG_STEP_HI = 5;
    typedef enum logic {IDLE, RAMP} ramp_state_t;
endpackage

// File: rtl/pwm_cmp_ramp_if.sv
// pwm_cmp_ramp_if: register-write bus from the I2C register interface.
// Signals: addr (REGBITS), data (8), valid (one-cycle write strobe).
// Modports: master drives the bus, slave receives it.
interface pwm_cmp_ramp_if #(parameter int REGBITS = 3);
    logic [REGBITS-1:0] addr;
    logic [7:0]         data;
    logic               valid;
    modport master (output addr, data, valid);
    modport slave  (input addr, data, valid);
endinterface

// File: rtl/pwm_cmp_stager.sv
// pwm_cmp_stager: byte-staging of the scratch compare word and slew step, plus commit strobe.
// Ports: clk, rst_n (async active-low), reg_if (slave register bus),
//        scratch_o (staged compare word), step_o (slew step), commit_o (commit strobe, comb).
module pwm_cmp_stager
    import pwm_pkg::*;
#(
    parameter int                WIDTH    = 19,
    parameter int                REGBITS  = 3,
    parameter int                STEPW    = 16,
    parameter logic [WIDTH-1:0]  CMP_RST  = 19'h50003,
    parameter logic [STEPW-1:0]  STEP_RST = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pwm_cmp_ramp_if.slave        reg_if,
    output logic [WIDTH-1:0]     scratch_o,
    output logic [STEPW-1:0]     step_o,
    output logic                 commit_o
);
    logic [WIDTH-1:0] scratch_q, scratch_d;
    logic [7:0]       step_lo_q, step_lo_d;
    logic [STEPW-1:0] step_q, step_d;
    logic [(1<<REGBITS)-1:0] sel;

    // One-hot decode of the written address; all zero when no write is strobed.
    assign sel = reg_if.valid ? (1 << reg_if.addr) : '0;

    always_comb begin
        scratch_d = scratch_q;
        step_lo_d = step_lo_q;
        step_d    = step_q;
        if (sel[REG_CMP0]) scratch_d[7:0] = reg_if.data;
        if (sel[REG_CMP1]) scratch_d[15:8] = reg_if.data;
        if (sel[REG_CMP2]) scratch_d[WIDTH-1:16] = reg_if.data[WIDTH-17:0];
        if (sel[REG_STEP_LO]) step_lo_d = reg_if.data;
        // High byte write loads the whole step at once so a half-updated step is never used.
        if (sel[REG_STEP_HI]) step_d = STEPW'({reg_if.data, step_lo_q});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scratch_q <= CMP_RST;
            step_lo_q <= '0;
            step_q    <= STEP_RST;
        end else begin
            scratch_q <= scratch_d;
            step_lo_q <= step_lo_d;
            step_q    <= step_d;
        end
    end

    assign scratch_o = scratch_q;
    assign step_o    = step_q;
    assign commit_o  = sel[REG_COMMIT];
endmodule

// File: rtl/pwm_cmp_ramp.sv
// pwm_cmp_ramp: slews the PWM compare word toward a committed target once per PWM period.
// Ports: clk, rst_n (async active-low), reg_if (slave register bus), period_tick_i,
//        cmp_o (compare word), busy_o (ramp in progress), done_o (target reached pulse).
// Build option: define CMPRAMP_LIMIT_EN to clamp committed targets to [CMP_MIN, CMP_MAX].
module pwm_cmp_ramp
    import pwm_pkg::*;
#(
    parameter int                WIDTH    = 19,
    parameter int                REGBITS  = 3,
    parameter int                STEPW    = 16,
    parameter logic [WIDTH-1:0]  CMP_RST  = 19'h50003,
    parameter logic [STEPW-1:0]  STEP_RST = '0,
    parameter logic [WIDTH-1:0]  CMP_MIN  = '0,
    parameter logic [WIDTH-1:0]  CMP_MAX  = '1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pwm_cmp_ramp_if.slave        reg_if,
    input  logic                 period_tick_i,
    output logic [WIDTH-1:0]     cmp_o,
    output logic                 busy_o,
    output logic                 done_o
);
`ifdef CMPRAMP_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    logic [WIDTH-1:0] scratch, tgt_new, cmp_q, cmp_d, tgt_q, tgt_d;
    logic [STEPW-1:0] step;
    logic [WIDTH:0]   diff;
    logic             commit, up, done_q, done_d;
    ramp_state_t      state_q, state_d;

    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] x, lo, hi);
        return x < lo ? lo : x > hi ? hi : x;
    endfunction

    pwm_cmp_stager #(
        .WIDTH(WIDTH), .REGBITS(REGBITS), .STEPW(STEPW), .CMP_RST(CMP_RST), .STEP_RST(STEP_RST)
    ) u_stager (
        .clk(clk), .rst_n(rst_n), .reg_if(reg_if),
        .scratch_o(scratch), .step_o(step), .commit_o(commit)
    );

    assign tgt_new = LIMIT_EN ? clamp(scratch, CMP_MIN, CMP_MAX) : scratch;
    assign up      = tgt_q > cmp_q;
    // Distance kept one bit wider than the word so the step comparison cannot wrap.
    assign diff    = up ? {1'b0, tgt_q} - {1'b0, cmp_q} : {1'b0, cmp_q} - {1'b0, tgt_q};

    always_comb begin
        cmp_d   = cmp_q;
        tgt_d   = tgt_q;
        state_d = state_q;
        done_d  = 1'b0;
        if (state_q == RAMP && period_tick_i) begin
            if (step == '0 || diff <= (WIDTH+1)'(step)) begin
                cmp_d   = tgt_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end else begin
                cmp_d = up ? cmp_q + WIDTH'(step) : cmp_q - WIDTH'(step);
            end
        end
        // A commit coinciding with a tick lets the tick finish against the old target first;
        // the ramp decision then compares the new target with the post-tick compare word.
        if (commit) begin
            tgt_d   = tgt_new;
            state_d = tgt_new != cmp_d ? RAMP : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_q   <= CMP_RST;
            tgt_q   <= CMP_RST;
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            cmp_q   <= cmp_d;
            tgt_q   <= tgt_d;
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign cmp_o  = cmp_q;
    assign busy_o = state_q == RAMP;
    assign done_o = done_q;
endmodule

// File: tb/tb_pwm_cmp_ramp.sv
// tb_pwm_cmp_ramp: directed self-checking bench for pwm_cmp_ramp.
module tb_pwm_cmp_ramp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic [18:0] cmp;
    logic        busy, done;
    int          passed = 0;
    int          total = 0;

    pwm_cmp_ramp_if #(.REGBITS(3)) bus ();

    pwm_cmp_ramp #(.CMP_MAX(19'h60000)) dut (
        .clk(clk), .rst_n(rst_n), .reg_if(bus), .period_tick_i(tick),
        .cmp_o(cmp), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.valid = 1'b1;
        bus.addr  = a;
        bus.data  = d;
        @(negedge clk);
        bus.valid = 1'b0;
    endtask

    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic set_scratch(input logic [18:0] v);
        wr(3'd0, v[7:0]);
        wr(3'd1, v[15:8]);
        wr(3'd2, {5'd0, v[18:16]});
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_cmp"}, 32'(cmp), 32'h50003);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reset, step 0x1000, target 0x53000, one tick -> compare word 0x51003 mid-ramp.
    task automatic setup_ramp(input string tag);
        do_reset({tag, "_rst"});
        wr(3'd4, 8'h00);
        wr(3'd5, 8'h10);
        set_scratch(19'h53000);
        wr(3'd3, 8'h00);
        do_tick();
        check({tag, "_first"}, 32'(cmp), 32'h51003);
    endtask

    initial begin
        bus.valid = 1'b0;
        bus.addr  = '0;
        bus.data  = '0;
        #12;
        check("rst_cmp", 32'(cmp), 32'h50003);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Jump with step 0
        set_scratch(19'h10000);
        check("stage_no_disturb", 32'(cmp), 32'h50003);
        wr(3'd3, 8'hAA);
        check("jump_busy", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        check("jump_hold", 32'(cmp), 32'h50003);
        do_tick();
        check("jump_cmp", 32'(cmp), 32'h10000);
        check("jump_done", 32'(done), 32'd1);
        check("jump_idle", 32'(busy), 32'd0);
        @(negedge clk);
        check("jump_done_pulse", 32'(done), 32'd0);

        // Ramp up by 0x1000
        setup_ramp("up");
        check("up_busy1", 32'(busy), 32'd1);
        do_tick();
        check("up_2", 32'(cmp), 32'h52003);
        check("up_busy2", 32'(busy), 32'd1);
        check("up_nodone", 32'(done), 32'd0);
        do_tick();
        check("up_3", 32'(cmp), 32'h53000);
        check("up_done", 32'(done), 32'd1);
        check("up_idle", 32'(busy), 32'd0);
        do_tick();
        check("up_idle_hold", 32'(cmp), 32'h53000);

        // Retarget down mid-ramp
        setup_ramp("rt");
        set_scratch(19'h50800);
        wr(3'd3, 8'h00);
        check("rt_busy", 32'(busy), 32'd1);
        check("rt_nojump", 32'(cmp), 32'h51003);
        do_tick();
        check("rt_cmp", 32'(cmp), 32'h50800);
        check("rt_done", 32'(done), 32'd1);

        // Commit and tick in the same cycle
        setup_ramp("ct");
        set_scratch(19'h40000);
        @(negedge clk);
        bus.valid = 1'b1;
        bus.addr  = 3'd3;
        tick      = 1'b1;
        @(negedge clk);
        bus.valid = 1'b0;
        tick      = 1'b0;
        check("ct_old_tgt", 32'(cmp), 32'h52003);
        check("ct_busy", 32'(busy), 32'd1);
        do_tick();
        check("ct_new_tgt", 32'(cmp), 32'h51003);

        // Async reset mid-ramp
        do_reset("midrst");
        do_tick();
        check("midrst_abandon", 32'(cmp), 32'h50003);

        // Commit equal to current compare word: no ramp, no done
        wr(3'd3, 8'h00);
        check("eq_busy", 32'(busy), 32'd0);
        do_tick();
        check("eq_done", 32'(done), 32'd0);

        // Ignored addresses and clamp behaviour
        set_scratch(19'h7FFFF);
        wr(3'd6, 8'h00);
        wr(3'd7, 8'h00);
        check("ign_busy", 32'(busy), 32'd0);
        wr(3'd3, 8'h00);
        do_tick();
`ifdef CMPRAMP_LIMIT_EN
        check("limit_cmp", 32'(cmp), 32'h60000);
`else
        check("limit_cmp", 32'(cmp), 32'h7FFFF);
`endif
        check("limit_done", 32'(done), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
